// File: rtl/calc_pkg.sv
// calc_pkg: shared constants for the calculator entry path.
// Key codes, one-hot state encoding, display constants.
package calc_pkg;

  localparam logic [7:0] KEY_ADD = 8'hF0;
  localparam logic [7:0] KEY_SUB = 8'hF1;
  localparam logic [7:0] KEY_MUL = 8'hF2;
  localparam logic [7:0] KEY_DIV = 8'hF3;
  localparam logic [7:0] KEY_EQU = 8'hE0;
  localparam logic [7:0] KEY_CLR = 8'hC0;

  localparam int N_ST   = 9;
  localparam int S_IDLE = 0;
  localparam int S_A1   = 1;
  localparam int S_A0   = 2;
  localparam int S_OP   = 3;
  localparam int S_B1   = 4;
  localparam int S_B0   = 5;
  localparam int S_CALC = 6;
  localparam int S_SHOW = 7;
  localparam int S_ERR  = 8;

  localparam logic [8:0] ST_IDLE = 9'b0_0000_0001;
  localparam logic [8:0] ST_A1   = 9'b0_0000_0010;
  localparam logic [8:0] ST_A0   = 9'b0_0000_0100;
  localparam logic [8:0] ST_OP   = 9'b0_0000_1000;
  localparam logic [8:0] ST_B1   = 9'b0_0001_0000;
  localparam logic [8:0] ST_B0   = 9'b0_0010_0000;
  localparam logic [8:0] ST_CALC = 9'b0_0100_0000;
  localparam logic [8:0] ST_SHOW = 9'b0_1000_0000;
  localparam logic [8:0] ST_ERR  = 9'b1_0000_0000;

  localparam logic [15:0] DISP_ERR = 16'h9404;

  typedef enum logic [2:0] {
    KC_NONE,
    KC_DIGIT,
    KC_OPER,
    KC_EQU,
    KC_CLR
  } key_class_e;

  typedef struct packed {
    logic [3:0] a1;
    logic [3:0] a0;
    logic [3:0] b1;
    logic [3:0] b0;
  } opnd_t;

  function automatic key_class_e key_class(
    input logic [7:0] c
  );
    key_class_e k;
    k = KC_NONE;
    if (c[7:4] == 4'h0 && c[3:0] <= 4'd9)
      k = KC_DIGIT;
    else if (c == KEY_ADD || c == KEY_SUB ||
             c == KEY_MUL || c == KEY_DIV)
      k = KC_OPER;
    else if (c == KEY_EQU)
      k = KC_EQU;
    else if (c == KEY_CLR)
      k = KC_CLR;
    return k;
  endfunction

endpackage

// File: rtl/calc_entry_sequencer_if.sv
// calc_entry_sequencer_if: keypad, datapath and display bundle.
// master = sequencer side, slave = keypad/datapath/display side.
interface calc_entry_sequencer_if;

  logic        key_pressed;
  logic [7:0]  key_code;
  logic        calc_done;
  logic [15:0] calc_bcd;
  logic [3:0]  opnd_a1;
  logic [3:0]  opnd_a0;
  logic [3:0]  opnd_b1;
  logic [3:0]  opnd_b0;
  logic [7:0]  opcode;
  logic        calc_start;
  logic [15:0] disp_digit;
  logic [3:0]  disp_blank;
  logic        error;

  modport master (
    input  key_pressed,
    input  key_code,
    input  calc_done,
    input  calc_bcd,
    output opnd_a1,
    output opnd_a0,
    output opnd_b1,
    output opnd_b0,
    output opcode,
    output calc_start,
    output disp_digit,
    output disp_blank,
    output error
  );

  modport slave (
    output key_pressed,
    output key_code,
    output calc_done,
    output calc_bcd,
    input  opnd_a1,
    input  opnd_a0,
    input  opnd_b1,
    input  opnd_b0,
    input  opcode,
    input  calc_start,
    input  disp_digit,
    input  disp_blank,
    input  error
  );

endinterface

// File: rtl/key_strobe_sync.sv
// key_strobe_sync: brings the async keypad level into clk
// and turns each rising edge into a one-cycle strobe.
module key_strobe_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic key_pressed,
  output logic key_stb
);

  logic [SYNC_STAGES-1:0] sync;
  logic                   prev;
  logic                   lvl;

  assign lvl = sync[SYNC_STAGES-1];

  // synchronizer chain plus one delay flop for edge detect
  always_ff @(posedge clk) begin
    if (rst) begin
      sync <= '0;
      prev <= 1'b0;
    end else begin
      sync <= {sync[SYNC_STAGES-2:0], key_pressed};
      prev <= lvl;
    end
  end

  assign key_stb = lvl & ~prev;

endmodule

// File: rtl/calc_entry_sequencer.sv
// calc_entry_sequencer: operand/operator entry FSM, calc
// handshake with timeout, and four-digit display mux.
module calc_entry_sequencer
  import calc_pkg::*;
#(
  parameter int SYNC_STAGES  = 2,
  parameter int CALC_TIMEOUT = 64
) (
  input logic                   clk,
  input logic                   rst,
  calc_entry_sequencer_if.master bus
);

  localparam int CW = $clog2(CALC_TIMEOUT + 1);
  localparam logic [CW-1:0] TMO = CW'(CALC_TIMEOUT);

  logic            key_stb;
  key_class_e      cls;
  logic [3:0]      dig;
  logic            dig_k;
  logic            op_k;
  logic            equ_k;
  logic            clr_k;

  logic [N_ST-1:0] state;
  logic [N_ST-1:0] nxt_state;
  opnd_t           opnd;
  opnd_t           nxt_opnd;
  logic [7:0]      opc;
  logic [7:0]      nxt_opc;
  logic [15:0]     res;
  logic [15:0]     nxt_res;
  logic [CW-1:0]   cnt;
  logic [CW-1:0]   nxt_cnt;
  logic            start_q;
  logic            nxt_start;

  logic [15:0]     disp_d;
  logic [15:0]     disp_q;
  logic [3:0]      blank_d;
  logic [3:0]      blank_q;
  logic            err_q;

  key_strobe_sync #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync (
    .clk        (clk),
    .rst        (rst),
    .key_pressed(bus.key_pressed),
    .key_stb    (key_stb)
  );

  assign cls   = key_class(bus.key_code);
  assign dig   = bus.key_code[3:0];
  assign dig_k = key_stb && (cls == KC_DIGIT);
  assign op_k  = key_stb && (cls == KC_OPER);
  assign equ_k = key_stb && (cls == KC_EQU);
  assign clr_k = key_stb && (cls == KC_CLR);

  // next state, operand latches, result latch and timeout count
  always_comb begin
    nxt_state = state;
    nxt_opnd  = opnd;
    nxt_opc   = opc;
    nxt_res   = res;
    nxt_cnt   = cnt;
    nxt_start = 1'b0;
    unique case (1'b1)
      state[S_IDLE]:
        if (dig_k) begin
          nxt_state   = ST_A1;
          nxt_opnd.a1 = dig;
        end
      state[S_A1]:
        if (dig_k) begin
          nxt_state   = ST_A0;
          nxt_opnd.a0 = dig;
        end
      state[S_A0]:
        if (op_k) begin
          nxt_state = ST_OP;
          nxt_opc   = bus.key_code;
        end
      state[S_OP]:
        if (dig_k) begin
          nxt_state   = ST_B1;
          nxt_opnd.b1 = dig;
        end
      state[S_B1]:
        if (dig_k) begin
          nxt_state   = ST_B0;
          nxt_opnd.b0 = dig;
        end
      state[S_B0]:
        if (equ_k) begin
          nxt_state = ST_CALC;
          nxt_start = 1'b1;
          nxt_cnt   = '0;
        end
      state[S_CALC]:
        if (bus.calc_done) begin
          nxt_state = ST_SHOW;
          nxt_res   = bus.calc_bcd;
        end else if (cnt == TMO) begin
          nxt_state = ST_ERR;
        end else begin
          nxt_cnt = cnt + 1'b1;
        end
      state[S_SHOW]:
        if (dig_k) begin
          nxt_state   = ST_A1;
          nxt_opnd    = '0;
          nxt_opnd.a1 = dig;
        end
      state[S_ERR]:
        nxt_state = ST_ERR;
      default:
        nxt_state = ST_IDLE;
    endcase
    if (clr_k) begin
      nxt_state = ST_IDLE;
      nxt_opnd  = '0;
      nxt_opc   = '0;
      nxt_res   = '0;
      nxt_cnt   = '0;
      nxt_start = 1'b0;
    end
  end

  // state and datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ST_IDLE;
      opnd    <= '0;
      opc     <= '0;
      res     <= '0;
      cnt     <= '0;
      start_q <= 1'b0;
    end else begin
      state   <= nxt_state;
      opnd    <= nxt_opnd;
      opc     <= nxt_opc;
      res     <= nxt_res;
      cnt     <= nxt_cnt;
      start_q <= nxt_start;
    end
  end

  // display content per state; d3 shows entry progress
  always_comb begin
    disp_d  = 16'h0000;
    blank_d = 4'b0111;
    unique case (1'b1)
      state[S_IDLE]: begin
        disp_d  = 16'h0000;
        blank_d = 4'b0111;
      end
      state[S_A1]: begin
        disp_d  = {4'd1, 8'h00, opnd.a1};
        blank_d = 4'b0110;
      end
      state[S_A0]: begin
        disp_d  = {4'd2, 4'd0, opnd.a1, opnd.a0};
        blank_d = 4'b0100;
      end
      state[S_OP]: begin
        disp_d  = 16'h3000;
        blank_d = 4'b0111;
      end
      state[S_B1]: begin
        disp_d  = {4'd3, 8'h00, opnd.b1};
        blank_d = 4'b0110;
      end
      state[S_B0], state[S_CALC]: begin
        disp_d  = {4'd4, 4'd0, opnd.b1, opnd.b0};
        blank_d = 4'b0100;
      end
      state[S_SHOW]: begin
        disp_d  = res;
        blank_d = 4'b0000;
      end
      state[S_ERR]: begin
        disp_d  = DISP_ERR;
        blank_d = 4'b0000;
      end
      default: begin
        disp_d  = 16'h0000;
        blank_d = 4'b0111;
      end
    endcase
  end

  // registered display and error outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      disp_q  <= 16'h0000;
      blank_q <= 4'b0111;
      err_q   <= 1'b0;
    end else begin
      disp_q  <= disp_d;
      blank_q <= blank_d;
      err_q   <= state[S_ERR];
    end
  end

  assign bus.opnd_a1    = opnd.a1;
  assign bus.opnd_a0    = opnd.a0;
  assign bus.opnd_b1    = opnd.b1;
  assign bus.opnd_b0    = opnd.b0;
  assign bus.opcode     = opc;
  assign bus.calc_start = start_q;
  assign bus.disp_digit = disp_q;
  assign bus.disp_blank = blank_q;
  assign bus.error      = err_q;

endmodule

// File: tb/tb_calc_entry_sequencer.sv
// tb_calc_entry_sequencer: directed key sequences checked
// against an expression-level model of the calculator.
module tb_calc_entry_sequencer;

  localparam int TMO    = 64;
  localparam int M_IDLE = 0;
  localparam int M_A1   = 1;
  localparam int M_A0   = 2;
  localparam int M_OP   = 3;
  localparam int M_B1   = 4;
  localparam int M_B0   = 5;
  localparam int M_CALC = 6;
  localparam int M_SHOW = 7;
  localparam int M_ERR  = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;

  int n_chk = 0;
  int n_fail = 0;
  int n_start = 0;
  int cyc = 0;
  int start_cyc = 0;

  logic        chk_en = 1'b0;
  logic        resp_en = 1'b0;
  int          resp_delay = 4;
  logic [15:0] resp_bcd = 16'h0;

  int          m_st;
  logic [3:0]  m_dg [4];
  logic [7:0]  m_op;
  logic [15:0] m_res;

  calc_entry_sequencer_if bus();

  calc_entry_sequencer #(
    .SYNC_STAGES (2),
    .CALC_TIMEOUT(TMO)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.master)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(
    input string       nm,
    input logic [31:0] act,
    input logic [31:0] exp
  );
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t",
               nm, act, exp, $time);
    end
  endtask

  task automatic model_clear();
    m_st = M_IDLE;
    for (int i = 0; i < 4; i++) m_dg[i] = 4'd0;
    m_op  = 8'h00;
    m_res = 16'h0000;
  endtask

  task automatic model_key(input logic [7:0] code);
    logic is_dig;
    logic is_op;
    is_dig = (code[7:4] == 4'h0) && (code[3:0] <= 4'd9);
    is_op  = (code >= 8'hF0) && (code <= 8'hF3);
    if (code == 8'hC0) begin
      model_clear();
    end else begin
      case (m_st)
        M_IDLE: if (is_dig) begin
          m_dg[0] = code[3:0]; m_st = M_A1;
        end
        M_A1: if (is_dig) begin
          m_dg[1] = code[3:0]; m_st = M_A0;
        end
        M_A0: if (is_op) begin
          m_op = code; m_st = M_OP;
        end
        M_OP: if (is_dig) begin
          m_dg[2] = code[3:0]; m_st = M_B1;
        end
        M_B1: if (is_dig) begin
          m_dg[3] = code[3:0]; m_st = M_B0;
        end
        M_B0: if (code == 8'hE0) m_st = M_CALC;
        M_SHOW: if (is_dig) begin
          for (int i = 1; i < 4; i++) m_dg[i] = 4'd0;
          m_dg[0] = code[3:0];
          m_st = M_A1;
        end
        default: ;
      endcase
    end
  endtask

  task automatic model_done(input logic [15:0] bcd);
    m_res = bcd;
    m_st  = M_SHOW;
  endtask

  function automatic logic [15:0] exp_disp();
    case (m_st)
      M_IDLE: return 16'h0000;
      M_A1:   return {4'd1, 8'h00, m_dg[0]};
      M_A0:   return {4'd2, 4'd0, m_dg[0], m_dg[1]};
      M_OP:   return 16'h3000;
      M_B1:   return {4'd3, 8'h00, m_dg[2]};
      M_B0, M_CALC:
              return {4'd4, 4'd0, m_dg[2], m_dg[3]};
      M_SHOW: return m_res;
      default: return 16'h9404;
    endcase
  endfunction

  function automatic logic [3:0] exp_blank();
    case (m_st)
      M_IDLE, M_OP: return 4'b0111;
      M_A1, M_B1:   return 4'b0110;
      M_A0, M_B0, M_CALC: return 4'b0100;
      default:      return 4'b0000;
    endcase
  endfunction

  always @(negedge clk) begin
    if (chk_en) begin
      check("a1", 32'(bus.opnd_a1), 32'(m_dg[0]));
      check("a0", 32'(bus.opnd_a0), 32'(m_dg[1]));
      check("b1", 32'(bus.opnd_b1), 32'(m_dg[2]));
      check("b0", 32'(bus.opnd_b0), 32'(m_dg[3]));
      check("opcode", 32'(bus.opcode), 32'(m_op));
      check("disp", 32'(bus.disp_digit), 32'(exp_disp()));
      check("blank", 32'(bus.disp_blank), 32'(exp_blank()));
      check("error", 32'(bus.error), 32'(m_st == M_ERR));
      check("start_idle", 32'(bus.calc_start), 32'd0);
    end
  end

  always @(negedge clk) begin
    if (bus.calc_start === 1'b1) begin
      n_start++;
      start_cyc = cyc;
    end
  end

  initial begin
    bus.calc_done = 1'b0;
    bus.calc_bcd  = 16'h0000;
    forever begin
      @(negedge clk);
      if (resp_en && bus.calc_start === 1'b1) begin
        repeat (resp_delay) @(posedge clk);
        #1;
        bus.calc_done = 1'b1;
        bus.calc_bcd  = resp_bcd;
        @(posedge clk);
        #1;
        bus.calc_done = 1'b0;
      end
    end
  end

  task automatic key(input logic [7:0] code, input int hold);
    chk_en = 1'b0;
    bus.key_code    = code;
    bus.key_pressed = 1'b1;
    repeat (hold) @(posedge clk);
    #1;
    bus.key_pressed = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    model_key(code);
  endtask

  task automatic settle();
    chk_en = 1'b1;
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic press(input logic [7:0] code);
    key(code, 6);
    settle();
  endtask

  initial begin
    int  n0;
    bit  got;
    bus.key_pressed = 1'b0;
    bus.key_code    = 8'h00;
    model_clear();

    repeat (2) @(posedge clk);
    #1;
    check("rst_disp", 32'(bus.disp_digit), 32'h0000);
    check("rst_blank", 32'(bus.disp_blank), 32'b0111);
    check("rst_error", 32'(bus.error), 32'd0);
    check("rst_start", 32'(bus.calc_start), 32'd0);
    check("rst_opcode", 32'(bus.opcode), 32'd0);
    rst = 1'b0;
    settle();

    resp_en = 1'b1;
    resp_delay = 4;
    resp_bcd = 16'h0046;
    press(8'h01);
    press(8'h02);
    press(8'hF0);
    press(8'h03);
    press(8'h04);
    key(8'hE0, 6);
    model_done(16'h0046);
    settle();
    check("t1_a1", 32'(bus.opnd_a1), 32'd1);
    check("t1_a0", 32'(bus.opnd_a0), 32'd2);
    check("t1_b1", 32'(bus.opnd_b1), 32'd3);
    check("t1_b0", 32'(bus.opnd_b0), 32'd4);
    check("t1_op", 32'(bus.opcode), 32'hF0);
    check("t1_disp", 32'(bus.disp_digit), 32'h0046);
    check("t1_blank", 32'(bus.disp_blank), 32'b0000);
    check("t1_nstart", n_start, 1);

    press(8'h05);
    check("t2_b0", 32'(bus.opnd_b0), 32'd0);
    press(8'hF0);
    check("t2_disp", 32'(bus.disp_digit), 32'h1005);
    check("t2_blank", 32'(bus.disp_blank), 32'b0110);

    press(8'hC0);
    key(8'h07, 50);
    settle();
    check("t3_disp", 32'(bus.disp_digit), 32'h1007);
    check("t3_a1", 32'(bus.opnd_a1), 32'd7);

    press(8'hC0);
    resp_en = 1'b0;
    press(8'h09);
    press(8'h08);
    press(8'hF3);
    press(8'h07);
    press(8'h06);
    key(8'hE0, 6);
    got = 1'b0;
    for (int i = 0; i < 200 && !got; i++) begin
      @(negedge clk);
      if (bus.error === 1'b1) got = 1'b1;
    end
    check("t4_err_seen", 32'(bus.error), 32'd1);
    if (got)
      check("t4_err_lat", cyc - start_cyc, TMO + 2);
    @(posedge clk);
    #1;
    m_st = M_ERR;
    settle();
    check("t4_disp", 32'(bus.disp_digit), 32'h9404);
    press(8'h05);
    press(8'hC0);
    check("t4_clr_disp", 32'(bus.disp_digit), 32'h0000);
    check("t4_clr_blank", 32'(bus.disp_blank), 32'b0111);

    resp_en = 1'b1;
    resp_delay = TMO;
    resp_bcd = 16'h0123;
    press(8'h01);
    press(8'h02);
    press(8'hF1);
    press(8'h03);
    press(8'h04);
    key(8'hE0, 6);
    repeat (70) @(posedge clk);
    #1;
    model_done(16'h0123);
    settle();
    check("t5_disp", 32'(bus.disp_digit), 32'h0123);

    press(8'hC0);
    press(8'h04);
    press(8'h05);
    press(8'hF2);
    press(8'h06);
    press(8'h07);
    chk_en = 1'b0;
    resp_delay = 3;
    resp_bcd = 16'h0099;
    bus.key_code = 8'hE0;
    bus.key_pressed = 1'b1;
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      if (bus.calc_start === 1'b1) got = 1'b1;
    end
    check("t6_start_seen", 32'(bus.calc_start), 32'd1);
    bus.key_pressed = 1'b0;
    bus.key_code = 8'hC0;
    model_key(8'hE0);
    @(posedge clk);
    #1;
    bus.key_pressed = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    bus.key_pressed = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    model_key(8'hC0);
    settle();
    check("t6_disp", 32'(bus.disp_digit), 32'h0000);
    check("t6_blank", 32'(bus.disp_blank), 32'b0111);

    resp_en = 1'b0;
    press(8'h01);
    press(8'h02);
    press(8'hF2);
    press(8'h03);
    chk_en = 1'b0;
    n0 = n_start;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check("t7_a1", 32'(bus.opnd_a1), 32'd0);
    check("t7_a0", 32'(bus.opnd_a0), 32'd0);
    check("t7_b1", 32'(bus.opnd_b1), 32'd0);
    check("t7_op", 32'(bus.opcode), 32'd0);
    check("t7_blank", 32'(bus.disp_blank), 32'b0111);
    model_clear();
    chk_en = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    check("t7_nostart", n_start, n0);

    chk_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/calc_entry_sequencer.md
# calc_entry_sequencer

Synchronous controller that sequences operand and operator entry for the two-digit calculator and hands a complete expression to the arithmetic/BCD datapath. Keypad events arrive as a level `key_pressed` with an 8-bit `key_code`. The block converts each press into a single-cycle strobe in the `clk` domain and drives the entry state machine. It issues a start/done handshake to the calculation unit and multiplexes the four display digits. It sits between the keypad encoder and the calculation/`UniversalBCD` path, and replaces the gated-clock press capture.

## Interface
- `SYNC_STAGES`, 2, synchronizer depth for `key_pressed` (≥2).
- `CALC_TIMEOUT`, 64, maximum cycles from `calc_start` to `calc_done` before error.
- `clk` in 1: single system clock.
- `rst` in 1: synchronous, active-high reset.
- `key_pressed` in 1: raw keypad level, asynchronous to `clk`.
- `key_code` in 8: encoded key, stable while `key_pressed` high.
- `calc_done` in 1: one-cycle pulse from the datapath, result valid.
- `calc_bcd` in 16: four BCD digits of the result, valid with `calc_done`.
- `opnd_a1`, `opnd_a0`, `opnd_b1`, `opnd_b0` out 4 each: operand digits, tens/units.
- `opcode` out 8: latched operator key code.
- `calc_start` out 1: one-cycle start pulse.
- `disp_digit` out 16: {d3,d2,d1,d0}, BCD.
- `disp_blank` out 4: per-digit blank mask, 1 = blank (bit3 ↔ d3).
- `error` out 1: high in ERR state.

## Operation
- Key classes: digit = `key_code[7:4]==4'h0` and low nibble ≤9; operator = 8'hF0 add, 8'hF1 sub, 8'hF2 mul, 8'hF3 div; `KEY_EQU`=8'hE0; `KEY_CLR`=8'hC0. Any other code is ignored.
- `key_pressed` passes through `SYNC_STAGES` flops. The rising edge of the synchronized level produces `key_stb` for exactly one cycle. `key_code` is sampled on that cycle.
- States and transitions on `key_stb`:
  - IDLE: digit → A1, latch `opnd_a1`.
  - A1: digit → A0.
  - A0: operator → OP.
  - OP: digit → B1.
  - B1: digit → B0.
  - B0: EQU → CALC, asserting `calc_start` on the transition cycle.
  - CALC: no key transitions except CLR. `calc_done` → SHOW, latch `calc_bcd`. Timeout counter reaching `CALC_TIMEOUT` → ERR.
  - SHOW: digit → A1, starting a new expression with that digit as `opnd_a1` and clearing all other operands.
  - ERR: any key except CLR is ignored.
- Wrong-class keys in any state are ignored, with no state change.
- CLR in any state → IDLE, clearing operands, opcode, result latch and counter.
- Display per state (d3 = progress index):
  - IDLE {0,-,-,-}
  - A1 {1,-,-,a1}
  - A0 {2,-,a1,a0}
  - OP {3,-,-,-}
  - B1 {3,-,-,b1}
  - B0 {4,-,b1,b0}
  - CALC {4,-,b1,b0}
  - SHOW latched `calc_bcd`, all unblanked
  - ERR {9,4,0,4}, all unblanked
  - '-' means the digit is blanked and its value is 0.

## Timing
- Reset: state IDLE; all operands and `opcode` = 0; `calc_start`=0; `error`=0; `disp_digit`=16'h0000; `disp_blank`=4'b0111.
- Press-to-state latency: `SYNC_STAGES`+1 cycles from the `key_pressed` rise to the state register update. Outputs are registered and valid the next cycle.
- Holding `key_pressed` high generates a single strobe. A new strobe requires the synchronized level to return low for ≥1 cycle.
- `calc_start` is high for exactly one cycle. Operands and `opcode` are held stable from that cycle until the block leaves CALC.
- The timeout counter starts at 0 on the `calc_start` cycle. ERR is entered on the cycle the count equals `CALC_TIMEOUT`, unless `calc_done` is high on that same cycle, in which case `calc_done` wins.
- `calc_done` outside CALC is ignored.
- CLR strobe coinciding with `calc_done`: CLR wins, result is discarded.
- `rst` overrides everything on the same edge, including mid-CALC. No `calc_start` is re-issued after reset.

## Structure
- Shared package `calc_pkg`:
  - key code constants `KEY_ADD/SUB/MUL/DIV/EQU/CLR`
  - state encoding (one-hot, 9 states)
  - display constant for ERR
- One sub-module `key_strobe_sync`: `SYNC_STAGES` synchronizer plus rising-edge detect, output `key_stb`.
- The FSM, operand registers, timeout counter and display mux live in `calc_entry_sequencer`.

## Test plan
- Reset, then press 1,2,F0,3,4,E0 with `calc_done` + `calc_bcd`=16'h0046 four cycles after `calc_start` → one `calc_start` pulse, `opnd`={1,2,3,4}, `opcode`=8'hF0, SHOW displays 0046 with blank 4'b0000.
- Press 5, then F0 while in A1 → F0 is ignored, state stays A1, display {1,-,-,5}.
- `key_pressed` held high for 50 cycles on digit 7 → exactly one strobe, state A1, `opnd_a1`=7.
- Full entry then EQU with no `calc_done` → ERR after 64 cycles, `error`=1, display 9404; CLR → IDLE, display {0,-,-,-}.
- CLR strobe on the same cycle as `calc_done` in CALC → IDLE, result not shown.
- `rst` asserted in B1 → next cycle IDLE, operands 0, `calc_start` never pulses.
